// File: rtl/shape_ctrl_pkg.sv
// rtl/shape_ctrl_pkg.sv - shared types and constants for the shape-select sequencer
// Contents: browse/full-screen state enum, shape index constants, commit position defaults.
package shape_ctrl_pkg;

    typedef enum logic {
        BROWSE = 1'b0,
        FULL   = 1'b1
    } state_e;

    localparam int SHAPE_CIRCLE   = 0;
    localparam int SHAPE_TRIANGLE = 1;
    localparam int SHAPE_SQUARE   = 2;
    localparam int SHAPE_RECT     = 3;

    // Commit point: first pixel of the first vertical-blank line.
    localparam int V_COMMIT_DEFAULT = 480;
    localparam int H_COMMIT         = 0;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debouncer and press-pulse generator
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn_raw      : raw asynchronous button level, active-high
//   press_pulse  : one-cycle pulse when a debounced 0->1 transition is accepted
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          samp_q, samp_d;
    logic          acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            samp_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            samp_q  <= samp_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        samp_d = sync2_q;
        cnt_d  = cnt_q;
        // Once the counter saturates, samp_q has been stable long enough.
        acc_d  = (cnt_q == CNT_MAX) ? samp_q : acc_q;
        if (sync2_q != samp_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // High exactly in the cycle before acc_q takes a new 1 level.
    assign press_pulse = (cnt_q == CNT_MAX) && samp_q && !acc_q;

endmodule

// File: rtl/shape_select_ctrl.sv
// rtl/shape_select_ctrl.sv - browse/full-screen sequencer with vblank-committed shape select
// Optional feature macro: SHAPE_AUTO_CYCLE_EN (idle auto-advance of the pending index).
// Ports:
//   clk, rst_n                              : pixel clock, asynchronous active-low reset
//   btn_next/btn_prev/btn_enter/btn_back    : raw active-high buttons
//   HCount, VCount                          : VGA timing position
//   shape_select                            : committed one-hot shape select
//   completeScreen                          : committed full-screen flag
//   cursor_idx                              : uncommitted pending index
module shape_select_ctrl
    import shape_ctrl_pkg::*;
#(
    parameter int NUM_SHAPES      = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int V_COMMIT        = V_COMMIT_DEFAULT
`ifdef SHAPE_AUTO_CYCLE_EN
    , parameter int AUTO_FRAMES   = 300
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          btn_next,
    input  logic                          btn_prev,
    input  logic                          btn_enter,
    input  logic                          btn_back,
    input  logic [9:0]                    HCount,
    input  logic [9:0]                    VCount,
    output logic [NUM_SHAPES-1:0]         shape_select,
    output logic                          completeScreen,
    output logic [$clog2(NUM_SHAPES)-1:0] cursor_idx
);

    localparam int IW = $clog2(NUM_SHAPES);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_SHAPES - 1);

    logic next_p, prev_p, enter_p, back_p;
    logic commit;

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  full_q, full_d;
    logic [NUM_SHAPES-1:0] sel_q, sel_d;
    logic                  scr_q, scr_d;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == IDX_MAX) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [IW-1:0] idx_dec(input logic [IW-1:0] i);
        return (i == '0) ? IDX_MAX : i - 1'b1;
    endfunction

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next  (.clk(clk), .rst_n(rst_n), .btn_raw(btn_next),  .press_pulse(next_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev  (.clk(clk), .rst_n(rst_n), .btn_raw(btn_prev),  .press_pulse(prev_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (.clk(clk), .rst_n(rst_n), .btn_raw(btn_enter), .press_pulse(enter_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back  (.clk(clk), .rst_n(rst_n), .btn_raw(btn_back),  .press_pulse(back_p));

    assign commit = (HCount == 10'(H_COMMIT)) && (VCount == 10'(V_COMMIT));

`ifdef SHAPE_AUTO_CYCLE_EN
    localparam int AW = $clog2(AUTO_FRAMES + 1);
    localparam logic [AW-1:0] IDLE_LAST = AW'(AUTO_FRAMES - 1);

    logic [AW-1:0] idle_q, idle_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BROWSE;
            idx_q   <= IW'(SHAPE_CIRCLE);
            full_q  <= 1'b0;
            sel_q   <= {{(NUM_SHAPES-1){1'b0}}, 1'b1};
            scr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
            sel_q   <= sel_d;
            scr_q   <= scr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        full_d  = full_q;
        sel_d   = sel_q;
        scr_d   = scr_q;

        // Commit samples the pending state as it was before this cycle's
        // pulses, so a coincident press lands on the following frame.
        if (commit) begin
            sel_d        = '0;
            sel_d[idx_q] = 1'b1;
            scr_d        = full_q;
        end

        case (state_q)
            BROWSE: begin
                if (enter_p) begin
                    full_d  = 1'b1;
                    state_d = FULL;
                end else if (next_p && !prev_p) begin
                    idx_d = idx_inc(idx_q);
                end else if (prev_p && !next_p) begin
                    idx_d = idx_dec(idx_q);
                end
            end
            FULL: begin
                if (back_p) begin
                    full_d  = 1'b0;
                    state_d = BROWSE;
                end
            end
        endcase

`ifdef SHAPE_AUTO_CYCLE_EN
        idle_d = idle_q;
        if (next_p || prev_p || enter_p || back_p || state_q != BROWSE) begin
            idle_d = '0;
        end else if (commit) begin
            if (idle_q == IDLE_LAST) begin
                idle_d = '0;
                idx_d  = idx_inc(idx_q);
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif
    end

    assign shape_select   = sel_q;
    assign completeScreen = scr_q;
    assign cursor_idx     = idx_q;

endmodule

// File: tb/tb_shape_select_ctrl.sv
// tb/tb_shape_select_ctrl.sv - self-checking bench for shape_select_ctrl
module tb_shape_select_ctrl;

    localparam int DB    = 16;
    localparam int FRAME = 80;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_next, btn_prev, btn_enter, btn_back;
    logic [9:0] HCount, VCount;
    logic [3:0] shape_select;
    logic       completeScreen;
    logic [1:0] cursor_idx;

    int compared   = 0;
    int mismatched = 0;
    int pos        = 0;

    shape_select_ctrl #(
        .NUM_SHAPES(4),
        .DEBOUNCE_CYCLES(DB),
        .V_COMMIT(480)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .btn_enter(btn_enter),
        .btn_back(btn_back),
        .HCount(HCount),
        .VCount(VCount),
        .shape_select(shape_select),
        .completeScreen(completeScreen),
        .cursor_idx(cursor_idx)
    );

    always #5 clk = ~clk;

    // Shortened frame: 4 columns x lines 470..489; strobe at pos 40 (H=0, V=480).
    always @(negedge clk) pos = (pos + 1) % FRAME;
    assign HCount = 10'(pos % 4);
    assign VCount = 10'(470 + pos / 4);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A button level counts as accepted once DB consecutive samples agree;
    // the resulting press reaches the sequencer three clocks later.
    int run_len[4];
    bit last_raw[4];
    bit acc_m[4];
    bit pipe[4][3];
    bit p_m[4];
    bit raw_m[4];
    bit new_p;
    int idx_m     = 0;
    bit full_m    = 0;
    int sel_idx_m = 0;
    bit scr_m     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                run_len[b] = 0; last_raw[b] = 0; acc_m[b] = 0;
                for (int s = 0; s < 3; s++) pipe[b][s] = 0;
            end
            idx_m = 0; full_m = 0; sel_idx_m = 0; scr_m = 0;
        end else begin
            raw_m[0] = btn_next; raw_m[1] = btn_prev; raw_m[2] = btn_enter; raw_m[3] = btn_back;
            for (int b = 0; b < 4; b++) p_m[b] = pipe[b][2];
            if (HCount == 0 && VCount == 480) begin
                sel_idx_m = idx_m;
                scr_m     = full_m;
            end
            if (!full_m) begin
                if (p_m[2]) full_m = 1;
                else if (p_m[0] && !p_m[1]) idx_m = (idx_m + 1) % 4;
                else if (p_m[1] && !p_m[0]) idx_m = (idx_m + 3) % 4;
            end else if (p_m[3]) begin
                full_m = 0;
            end
            for (int b = 0; b < 4; b++) begin
                run_len[b]  = (raw_m[b] == last_raw[b]) ? run_len[b] + 1 : 1;
                last_raw[b] = raw_m[b];
                new_p = 0;
                if (run_len[b] >= DB && raw_m[b] != acc_m[b]) begin
                    acc_m[b] = raw_m[b];
                    new_p    = raw_m[b];
                end
                pipe[b][2] = pipe[b][1];
                pipe[b][1] = pipe[b][0];
                pipe[b][0] = new_p;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_shape_select", 32'(shape_select), 32'(1 << sel_idx_m));
            check("cyc_completeScreen", 32'(completeScreen), 32'(scr_m));
            check("cyc_cursor_idx", 32'(cursor_idx), 32'(idx_m));
            check("cyc_onehot", 32'($onehot(shape_select)), 32'd1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (pos != p && n < 2 * FRAME);
        if (pos != p) check("wait_pos_timeout", 32'(pos), 32'(p));
    endtask

    task automatic set_btns(input logic [3:0] m);
        btn_next = m[0]; btn_prev = m[1]; btn_enter = m[2]; btn_back = m[3];
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        set_btns(m);
        cyc(hold);
        set_btns(4'b0000);
        cyc(40);
    endtask

    localparam logic [3:0] B_NEXT = 4'b0001, B_PREV = 4'b0010, B_ENTER = 4'b0100, B_BACK = 4'b1000;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_btns(4'b0000);
        cyc(3);
        check("reset_sel", 32'(shape_select), 32'h1);
        check("reset_full", 32'(completeScreen), 32'h0);
        check("reset_cursor", 32'(cursor_idx), 32'h0);
        rst_n = 1'b1;
        cyc(2);
        check("post_reset_sel", 32'(shape_select), 32'h1);

        // Wrap and commit gating
        wait_pos(42);
        set_btns(B_NEXT);
        cyc(40);
        check("wrap_cursor1", 32'(cursor_idx), 32'd1);
        check("wrap_sel_precommit", 32'(shape_select), 32'h1);
        set_btns(4'b0000);
        wait_pos(40);
        check("wrap_sel_at_strobe", 32'(shape_select), 32'h1);
        cyc(1);
        check("wrap_sel_after_strobe", 32'(shape_select), 32'h2);
        press(B_NEXT, 40);
        check("wrap_cursor2", 32'(cursor_idx), 32'd2);
        press(B_NEXT, 40);
        check("wrap_cursor3", 32'(cursor_idx), 32'd3);
        press(B_NEXT, 40);
        check("wrap_cursor0", 32'(cursor_idx), 32'd0);
        wait_pos(41);
        check("wrap_sel_back_to_0", 32'(shape_select), 32'h1);

        // Debounce glitch, then a real prev press wrapping 0 -> 3
        press(B_PREV, 5);
        check("glitch_cursor", 32'(cursor_idx), 32'd0);
        press(B_PREV, 30);
        check("prev_wrap_cursor", 32'(cursor_idx), 32'd3);
        wait_pos(41);
        check("prev_wrap_sel", 32'(shape_select), 32'h8);

        // Full-screen flow at idx 2
        press(B_PREV, 40);
        wait_pos(41);
        check("full_sel_idx2", 32'(shape_select), 32'h4);
        press(B_ENTER, 40);
        check("full_cursor", 32'(cursor_idx), 32'd2);
        wait_pos(41);
        check("full_on", 32'(completeScreen), 32'd1);
        press(B_NEXT, 40);
        check("full_next_ignored", 32'(cursor_idx), 32'd2);
        wait_pos(41);
        check("full_sel_kept", 32'(shape_select), 32'h4);
        press(B_BACK, 40);
        wait_pos(41);
        check("full_off", 32'(completeScreen), 32'd0);

        // Simultaneous events
        press(B_NEXT | B_PREV, 40);
        check("next_prev_cancel", 32'(cursor_idx), 32'd2);
        press(B_ENTER | B_NEXT, 40);
        check("enter_wins_cursor", 32'(cursor_idx), 32'd2);
        wait_pos(41);
        check("enter_wins_full", 32'(completeScreen), 32'd1);
        check("enter_wins_sel", 32'(shape_select), 32'h4);
        press(B_BACK, 40);
        wait_pos(41);
        check("back_again_full", 32'(completeScreen), 32'd0);

        // Pulse coincident with the commit strobe
        wait_pos(22);
        set_btns(B_NEXT);
        wait_pos(41);
        check("coinc_cursor", 32'(cursor_idx), 32'd3);
        check("coinc_sel_old", 32'(shape_select), 32'h4);
        cyc(21);
        set_btns(4'b0000);
        cyc(40);
        wait_pos(41);
        check("coinc_sel_next_frame", 32'(shape_select), 32'h8);

        // Reset in FULL with idx 3 and a partially debounced press
        press(B_ENTER, 40);
        wait_pos(41);
        check("pre_reset_full", 32'(completeScreen), 32'd1);
        set_btns(B_NEXT);
        cyc(8);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_sel", 32'(shape_select), 32'h1);
        check("async_reset_full", 32'(completeScreen), 32'd0);
        check("async_reset_cursor", 32'(cursor_idx), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        set_btns(4'b0000);
        cyc(40);
        check("partial_discarded", 32'(cursor_idx), 32'd0);
        wait_pos(41);
        check("post_reset_commit_sel", 32'(shape_select), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shape_select_ctrl.md
Name: shape_select_ctrl

Overview:
- Sequencer for the VGA shape-object layer.
- Turns four raw push-buttons into the one-hot `shape_select` lines and the `completeScreen` flag that every shape object (circle, triangle, square, …) consumes.
- Runs a browse/full-screen FSM.
- Changes to the displayed outputs take effect only at the start of vertical blank, so no object moves or disappears mid-frame.

Parameters:
- NUM_SHAPES, 4, number of selectable shape objects; index width is $clog2(NUM_SHAPES).
- DEBOUNCE_CYCLES, 250000, cycles a synchronized button level must be stable before it is accepted (10 ms at 25 MHz).
- V_COMMIT, 480, VCount value at which pending selection is committed (with HCount==0).
- AUTO_FRAMES, 300, idle frames before auto-advance (used only with the optional feature).

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- btn_next  in  1  raw button, active-high, asynchronous
- btn_prev  in  1  raw button, active-high, asynchronous
- btn_enter  in  1  raw button, active-high, asynchronous
- btn_back  in  1  raw button, active-high, asynchronous
- HCount  in  10  current pixel column from the VGA timing generator
- VCount  in  10  current line from the VGA timing generator
- shape_select  out  NUM_SHAPES  one-hot committed selection, bit i drives shape i's select input
- completeScreen  out  1  committed full-screen flag
- cursor_idx  out  $clog2(NUM_SHAPES)  pending (not yet committed) index, for debug LEDs

Behaviour:
- Reset (async, rst_n=0):
  - state=BROWSE, pending_idx=0, pending_full=0.
  - shape_select=1 (bit0 only), completeScreen=0, cursor_idx=0.
  - All synchronizers and debounce counters are cleared.
  - Reset asserted mid-debounce or mid-frame discards any pending change.
- Input path per button:
  - 2-flop synchronizer, then debounce counter.
  - Counter reloads on any level change and counts to DEBOUNCE_CYCLES-1.
  - On reaching it, the stable level is accepted.
  - A 0→1 transition of the accepted level emits a one-cycle press pulse.
  - Latency from a clean raw edge to pulse: 2+DEBOUNCE_CYCLES cycles.
  - Holding a button produces exactly one pulse; no auto-repeat.
- FSM, evaluated on pulses:
  - BROWSE:
    - next: pending_idx+1, wraps NUM_SHAPES-1→0.
    - prev: pending_idx-1, wraps 0→NUM_SHAPES-1.
    - enter: pending_full=1, go to FULL.
    - back: ignored.
  - FULL:
    - back: pending_full=0, go to BROWSE.
    - next/prev/enter: ignored.
- Simultaneous pulses:
  - next+prev in the same cycle: no index change.
  - In BROWSE, enter with next/prev: enter wins, index unchanged.
  - In FULL, back wins over everything.
- Commit strobe: HCount==0 && VCount==V_COMMIT, one cycle per frame.
  - On the strobe: shape_select ← onehot(pending_idx), completeScreen ← pending_full.
  - A pulse arriving in the same cycle as the strobe updates pending state that cycle and is committed at the next frame's strobe.
  - Visible latency from pulse to outputs: ≤1 frame.
- cursor_idx follows pending_idx with no commit gating.
- shape_select is always exactly one-hot; never zero, never multi-hot.

Optional Feature:
- Macro: SHAPE_AUTO_CYCLE_EN.
- Defined: an idle counter increments on each commit strobe while in BROWSE and is cleared by any press pulse or by leaving BROWSE. When it reaches AUTO_FRAMES, pending_idx advances by one (wrapping) and the counter clears.
- Undefined: the counter logic is absent; pending_idx changes only on button pulses.

Decomposition:
- Package shape_ctrl_pkg:
  - state enum {BROWSE, FULL}.
  - Shape index constants SHAPE_CIRCLE=0, SHAPE_TRIANGLE=1, SHAPE_SQUARE=2, SHAPE_RECT=3.
  - Default V_COMMIT and H_COMMIT=0.
- One sub-module, btn_debounce (synchronizer + counter + rising-edge pulse), instantiated four times.
- The FSM and commit registers stay in the top.

Test Plan (DEBOUNCE_CYCLES=16, shortened frame timing allowed):
- Reset check: hold rst_n=0, then release → shape_select=4'b0001, completeScreen=0, cursor_idx=0.
- Wrap: btn_next pressed 4 times, 40 cycles each → cursor_idx sequence 1,2,3,0; shape_select changes only on the cycle after HCount=0/VCount=480.
- Debounce: btn_prev raw-glitched 5 cycles high then low → no pulse, cursor_idx unchanged. Then held 30 cycles from idx 0 → cursor_idx=3, and after commit shape_select=4'b1000.
- Full-screen flow: at idx 2, press enter → completeScreen=1 at next commit. Then press next → ignored (shape_select stays 4'b0100). Then press back → completeScreen=0 at the following commit.
- Simultaneous events: next+prev pulses in the same cycle → idx unchanged. Enter+next in BROWSE → FULL with idx unchanged. Pulse coincident with the commit strobe → committed one frame later.
- Reset mid-operation: assert rst_n=0 during FULL with idx 3 → outputs return to 4'b0001/0 immediately (asynchronously), and the partially counted debounce is discarded.
